// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 18;
  localparam int INSTR_W_DEF = 18;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDPC = 3'd1,
    ST_CAPT = 3'd2,
    ST_MEM  = 3'd3,
    ST_INC  = 3'd4,
    ST_DISP = 3'd5,
    ST_BR   = 3'd6,
    ST_ERR  = 3'd7
  } fetch_state_t;

  // Wide enough to hold every value from 0 up to wait_max.
  function automatic int wait_cnt_w(input int wait_max);
    return $clog2(wait_max + 1);
  endfunction

endpackage

// File: rtl/fetch_timeout.sv
// Memory wait counter: counts stalled MEM cycles and flags the last allowed one.
module fetch_timeout
  import fetch_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = wait_cnt_w(WAIT_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // High in the WAIT_MAX-th stalled cycle; a miss in that cycle is fatal.
  assign tc = (count == TC_VAL);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the PC strobes, fetches from memory and
// hands instructions to decode, redirecting the PC on taken branches.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt,
  output logic               re_PC,
  output logic               wr_PC,
  output logic               PCinc,
  output logic [ADDR_W-1:0]  PCin,
  input  logic [ADDR_W-1:0]  PCout,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               br_req,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               br_ack,
  output logic               fetch_err,
  output logic               busy
);

  localparam int CNT_W = wait_cnt_w(WAIT_MAX);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] tgt_q;
  logic              hs;
  logic              tmo_clr;
  logic              tmo_en;
  logic              tmo_tc;

  assign hs      = (state == ST_DISP) && ir_ready;
  assign tmo_clr = (state != ST_MEM) || mem_ack;
  assign tmo_en  = (state == ST_MEM) && !mem_ack;

  fetch_timeout #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmo_clr),
    .en       (tmo_en),
    .load     (1'b0),
    .load_val ('0),
    .tc       (tmo_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (run && !halt) state_nxt = ST_RDPC;
      ST_RDPC: state_nxt = ST_CAPT;
      ST_CAPT: state_nxt = ST_MEM;
      ST_MEM: begin
        if (mem_ack)     state_nxt = ST_INC;
        else if (tmo_tc) state_nxt = ST_ERR;
      end
      ST_INC:  state_nxt = ST_DISP;
      ST_DISP: begin
        // A branch wins over halt; halt is honoured after the PC reload.
        if (ir_ready) begin
          if (br_req)    state_nxt = ST_BR;
          else if (halt) state_nxt = ST_IDLE;
          else           state_nxt = ST_RDPC;
        end
      end
      ST_BR:   state_nxt = halt ? ST_IDLE : ST_RDPC;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      ir       <= '0;
      tgt_q    <= '0;
    end else begin
      if (state == ST_CAPT)           mem_addr <= PCout;
      if (state == ST_MEM && mem_ack) ir       <= mem_rdata;
      if (hs && br_req)               tgt_q    <= br_target;
    end
  end

  // PC strobes are suppressed while reset is asserted so an aborted
  // sequence never disturbs the PC register.
  assign re_PC     = (state == ST_RDPC) && !rst;
  assign PCinc     = (state == ST_INC)  && !rst;
  assign wr_PC     = (state == ST_BR)   && !rst;
  assign br_ack    = (state == ST_BR);
  assign PCin      = tgt_q;
  assign mem_rd    = (state == ST_MEM);
  assign ir_valid  = (state == ST_DISP);
  assign fetch_err = (state == ST_ERR);
  assign busy      = (state != ST_IDLE) && (state != ST_ERR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC/memory environment, event-level reference model
// checked every cycle, plus directed literal checks.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int ADDR_W   = 18;
  localparam int INSTR_W  = 18;
  localparam int WAIT_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic halt = 1'b0;
  logic ir_ready = 1'b0;
  logic br_req = 1'b0;
  logic [ADDR_W-1:0] br_target = '0;

  logic re_PC, wr_PC, PCinc, mem_rd, ir_valid, br_ack, fetch_err, busy, mem_ack;
  logic [ADDR_W-1:0]  PCin, PCout, mem_addr;
  logic [INSTR_W-1:0] ir, mem_rdata;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .halt      (halt),
    .re_PC     (re_PC),
    .wr_PC     (wr_PC),
    .PCinc     (PCinc),
    .PCin      (PCin),
    .PCout     (PCout),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .br_req    (br_req),
    .br_target (br_target),
    .br_ack    (br_ack),
    .fetch_err (fetch_err),
    .busy      (busy)
  );

  function automatic logic [INSTR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return a ^ 18'h2A5A5;
  endfunction

  // PC register environment; PCout carries junk outside the cycle after re_PC.
  logic              pc_load = 1'b0;
  logic [ADDR_W-1:0] pc_load_val = '0;
  logic [ADDR_W-1:0] pc_reg = '0;
  logic [ADDR_W-1:0] pc_out_q = '0;

  always @(posedge clk) begin
    if (pc_load)    pc_reg <= pc_load_val;
    else if (wr_PC) pc_reg <= PCin;
    else if (PCinc) pc_reg <= pc_reg + 1'b1;
    pc_out_q <= re_PC ? pc_reg : 18'h15555;
  end
  assign PCout = pc_out_q;

  // Memory acknowledges in the (ack_delay+1)-th request cycle when enabled.
  logic ack_en = 1'b1;
  int   ack_delay = 0;
  int   mem_wait = 0;

  always @(posedge clk) mem_wait <= (mem_rd && !mem_ack) ? mem_wait + 1 : 0;
  assign mem_ack   = mem_rd && ack_en && (mem_wait == ack_delay);
  assign mem_rdata = word_of(mem_addr);

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one flag per activity the rules say can be in progress.
  logic checking = 1'b0;
  logic m_idle = 1'b1, m_re = 1'b0, m_capt = 1'b0, m_mem = 1'b0;
  logic m_inc = 1'b0, m_disp = 1'b0, m_br = 1'b0, m_err = 1'b0;
  int   m_stall = 0;
  logic [ADDR_W-1:0]  m_pc = '0, m_addr = '0, m_tgt = '0;
  logic [INSTR_W-1:0] m_ir = '0;
  logic hs_m, start_m, n_re, n_capt, n_mem, n_inc, n_disp, n_br, n_err, n_idle;

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("re_PC", re_PC, m_re && !rst);
      checkOutput("wr_PC", wr_PC, m_br && !rst);
      checkOutput("PCinc", PCinc, m_inc && !rst);
      checkOutput("br_ack", br_ack, m_br);
      checkOutput("mem_rd", mem_rd, m_mem);
      checkOutput("ir_valid", ir_valid, m_disp);
      checkOutput("fetch_err", fetch_err, m_err);
      checkOutput("busy", busy, !(m_idle || m_err));
      checkOutput("mem_addr", mem_addr, m_addr);
      checkOutput("ir", ir, m_ir);
      checkOutput("PCin", PCin, m_tgt);
      checkOutput("strobe_excl", $countones({re_PC, wr_PC, PCinc}) <= 1, 1'b1);
    end

    hs_m    = m_disp && ir_ready;
    start_m = run && !halt;
    if (pc_load)            m_pc = pc_load_val;
    else if (!rst && m_inc) m_pc = m_pc + 1'b1;
    else if (!rst && m_br)  m_pc = m_tgt;

    if (rst) begin
      {m_re, m_capt, m_mem, m_inc, m_disp, m_br, m_err} = '0;
      m_idle  = 1'b1;
      m_stall = 0;
      m_addr  = '0;
      m_ir    = '0;
      m_tgt   = '0;
    end else begin
      n_re   = (m_idle && start_m) || (hs_m && !br_req && !halt) || (m_br && !halt);
      n_capt = m_re;
      n_mem  = m_capt || (m_mem && !mem_ack && (m_stall + 1 < WAIT_MAX));
      n_err  = m_err || (m_mem && !mem_ack && (m_stall + 1 >= WAIT_MAX));
      n_inc  = m_mem && mem_ack;
      n_disp = m_inc || (m_disp && !ir_ready);
      n_br   = hs_m && br_req;
      n_idle = (m_idle && !start_m) || (hs_m && !br_req && halt) || (m_br && halt);
      if (m_capt)           m_addr = pc_reg;
      if (m_mem && mem_ack) m_ir = word_of(m_addr);
      if (hs_m && br_req)   m_tgt = br_target;
      m_stall = (m_mem && !mem_ack) ? m_stall + 1 : 0;
      {m_re, m_capt, m_mem, m_inc, m_disp, m_br, m_err, m_idle} =
        {n_re, n_capt, n_mem, n_inc, n_disp, n_br, n_err, n_idle};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic rdy,
                               input logic br, input logic [ADDR_W-1:0] tgt);
    run = r; halt = h; ir_ready = rdy; br_req = br; br_target = tgt;
  endtask

  task automatic waitValid(input string name);
    int k = 0;
    while (!ir_valid && k < 60) begin tick(); k++; end
    checkOutput(name, ir_valid, 1'b1);
  endtask

  task automatic waitMemRd(input string name);
    int k = 0;
    while (!mem_rd && k < 60) begin tick(); k++; end
    checkOutput(name, mem_rd, 1'b1);
  endtask

  initial begin
    rst = 1'b1; pc_load = 1'b1; pc_load_val = 18'h00010;
    tick();
    pc_load = 1'b0; checking = 1'b1;
    tick();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 18'h0);
    checkOutput("rst_ir", ir, 18'h0);
    rst = 1'b0;

    // Basic fetch from 0x00010 with zero-wait memory.
    applyStimulus(1, 0, 0, 0, '0);
    tick(); checkOutput("c1_re_PC", re_PC, 1'b1);
    tick(); checkOutput("c2_mem_rd", mem_rd, 1'b0);
    tick(); checkOutput("c3_mem_rd", mem_rd, 1'b1);
            checkOutput("c3_mem_addr", mem_addr, 18'h00010);
    tick(); checkOutput("c4_PCinc", PCinc, 1'b1);
    tick(); checkOutput("c5_ir_valid", ir_valid, 1'b1);
            checkOutput("c5_ir", ir, 18'h2A5B5);

    // Decoder stalls, then accepts.
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_ir", ir, 18'h2A5B5);
      checkOutput("stall_re_PC", re_PC, 1'b0);
    end
    ir_ready = 1'b1;
    tick(); checkOutput("after_hs_re_PC", re_PC, 1'b1);
    ir_ready = 1'b0;
    tick();
    tick(); checkOutput("seq_mem_addr", mem_addr, 18'h00011);
    applyStimulus(1, 0, 0, 1, 18'h12345);
    tick(); checkOutput("ignored_br_ack", br_ack, 1'b0);
    applyStimulus(1, 0, 0, 0, '0);
    tick(); checkOutput("seq_ir", ir, 18'h2A5B4);

    // Taken branch on the handshake.
    applyStimulus(1, 0, 1, 1, 18'h3FFF0);
    tick(); checkOutput("br_wr_PC", wr_PC, 1'b1);
            checkOutput("br_ack", br_ack, 1'b1);
            checkOutput("br_PCin", PCin, 18'h3FFF0);
    applyStimulus(1, 0, 0, 0, '0);
    tick(); checkOutput("post_br_ack", br_ack, 1'b0);
    tick();
    tick(); checkOutput("br_mem_addr", mem_addr, 18'h3FFF0);
    tick(); ack_delay = 14;
    tick(); checkOutput("br_ir", ir, 18'h15A55);
    ir_ready = 1'b1;
    tick(); ir_ready = 1'b0;
    tick();

    // Ack on the last allowed wait cycle is accepted.
    tick(); checkOutput("slow_mem_addr", mem_addr, 18'h3FFF1);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("slow_mem_rd_15", mem_rd, 1'b1);
    tick(); checkOutput("slow_PCinc", PCinc, 1'b1);
    ack_en = 1'b0;
    tick(); ir_ready = 1'b1;
    tick(); ir_ready = 1'b0;
    tick();

    // Ack never arrives: timeout into a sticky error.
    tick(); checkOutput("tmo_mem_addr", mem_addr, 18'h3FFF2);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("tmo_mem_rd_15", mem_rd, 1'b1);
    tick(); checkOutput("tmo_fetch_err", fetch_err, 1'b1);
            checkOutput("tmo_mem_rd", mem_rd, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("tmo_sticky", fetch_err, 1'b1);
    rst = 1'b1; run = 1'b0;
    tick(); checkOutput("tmo_cleared", fetch_err, 1'b0);
    rst = 1'b0; ack_en = 1'b1; ack_delay = 0;

    // Halt on a handshake returns to IDLE.
    pc_load = 1'b1; pc_load_val = 18'h00100;
    tick(); pc_load = 1'b0;
    applyStimulus(1, 0, 0, 0, '0);
    waitValid("halt_fetch_valid");
    checkOutput("halt_fetch_ir", ir, 18'h2A4A5);
    applyStimulus(1, 1, 1, 0, '0);
    tick(); checkOutput("halt_busy", busy, 1'b0);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("halt_no_re_PC", re_PC, 1'b0);
    end

    // Branch and halt together: branch first, then IDLE.
    applyStimulus(1, 0, 0, 0, '0);
    waitValid("brhalt_valid");
    checkOutput("brhalt_ir", ir, 18'h2A4A4);
    applyStimulus(1, 1, 1, 1, 18'h00200);
    tick(); checkOutput("brhalt_br_ack", br_ack, 1'b1);
    applyStimulus(1, 1, 0, 0, '0);
    tick(); checkOutput("brhalt_busy", busy, 1'b0);
            checkOutput("brhalt_re_PC", re_PC, 1'b0);

    // Reset in the middle of a memory wait.
    ack_en = 1'b0;
    applyStimulus(1, 0, 0, 0, '0);
    waitMemRd("rstmem_mem_rd");
    checkOutput("rstmem_addr", mem_addr, 18'h00200);
    rst = 1'b1;
    tick(); checkOutput("rstmem_mem_rd_off", mem_rd, 1'b0);
            checkOutput("rstmem_busy", busy, 1'b0);
            checkOutput("rstmem_PCin", PCin, 18'h0);
    rst = 1'b0; run = 1'b0; ack_en = 1'b1;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
